// File: rtl/cam_pattern_gen.sv
// Parallel-camera (DVP) frame source: vsync/href/data framing with four test patterns,
// frame counting and enable-gated continuous or stop-after-frame operation.
module cam_pattern_gen #(
  parameter int          FRAME_WIDTH     = 100,
  parameter int          FRAME_HEIGHT    = 70,
  parameter int          BYTES_PER_PIXEL = 2,
  parameter int          DATA_WIDTH      = 8,
  parameter int          VSYNC_CYCLES    = 100,
  parameter int          VBP_CYCLES      = 100,
  parameter int          HBLANK_CYCLES   = 10,
  parameter int          STARTUP_CYCLES  = 1000,
  parameter logic [7:0]  SEED            = 8'hEE
) (
  input  logic                  cam_pclk,
  input  logic                  cam_rst,
  input  logic                  enable,
  input  logic [1:0]            mode,
  output logic                  cam_vsync,
  output logic                  cam_href,
  output logic [DATA_WIDTH-1:0] cam_data,
  output logic [15:0]           frame_cnt,
  output logic                  frame_done,
  output logic                  busy
);

  localparam int LINE_BEATS = FRAME_WIDTH * BYTES_PER_PIXEL;

  // One shared phase counter serves every timed state, so size it for the longest one.
  localparam int MAX_A   = (STARTUP_CYCLES > VSYNC_CYCLES) ? STARTUP_CYCLES : VSYNC_CYCLES;
  localparam int MAX_B   = (VBP_CYCLES > HBLANK_CYCLES) ? VBP_CYCLES : HBLANK_CYCLES;
  localparam int MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_MAX = (MAX_C > LINE_BEATS) ? MAX_C : LINE_BEATS;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int LINE_W  = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;

  localparam logic [CNT_W-1:0]      STARTUP_LAST = CNT_W'(STARTUP_CYCLES - 1);
  localparam logic [CNT_W-1:0]      VSYNC_LAST   = CNT_W'(VSYNC_CYCLES - 1);
  localparam logic [CNT_W-1:0]      VBP_LAST     = CNT_W'(VBP_CYCLES - 1);
  localparam logic [CNT_W-1:0]      BEAT_LAST    = CNT_W'(LINE_BEATS - 1);
  localparam logic [CNT_W-1:0]      HBLANK_LAST  = CNT_W'(HBLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0]      CNT_ONE      = CNT_W'(1);
  localparam logic [LINE_W-1:0]     LINE_LAST    = LINE_W'(FRAME_HEIGHT - 1);
  localparam logic [LINE_W-1:0]     LINE_ONE     = LINE_W'(1);
  localparam logic [DATA_WIDTH-1:0] SEED_EXT     = DATA_WIDTH'(SEED);

  typedef enum logic [2:0] {
    ST_STARTUP,
    ST_IDLE,
    ST_VSYNC,
    ST_VBP,
    ST_ACTIVE,
    ST_HBLANK
  } state_t;

  state_t                state_reg, state_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic [LINE_W-1:0]     line_reg, line_next;
  logic [1:0]            mode_reg, mode_next;
  logic [15:0]           frame_cnt_reg, frame_cnt_next;
  logic [DATA_WIDTH-1:0] rot_reg, rot_next;

  logic                  vsync_reg, vsync_next;
  logic                  href_reg, href_next;
  logic [DATA_WIDTH-1:0] data_reg, data_next;
  logic                  done_reg, done_next;
  logic                  busy_reg, busy_next;

  logic                  in_active;
  logic                  beat_b3;
  logic                  line_b3;

  // Free-running rotate-left; it advances every cycle so mode 0 always shows the
  // sequence position relative to reset, whatever mode preceded it.
  for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_rot
    assign rot_next[gi] = rot_reg[(gi + DATA_WIDTH - 1) % DATA_WIDTH];
  end

  if (CNT_W > 3) begin : g_beat_b3
    assign beat_b3 = cnt_next[3];
  end else begin : g_beat_b3_zero
    assign beat_b3 = 1'b0;
  end

  if (LINE_W > 3) begin : g_line_b3
    assign line_b3 = line_next[3];
  end else begin : g_line_b3_zero
    assign line_b3 = 1'b0;
  end

  // Sequencer: next state, phase counter, line index, mode latch and frame count.
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    line_next      = line_reg;
    mode_next      = mode_reg;
    frame_cnt_next = frame_cnt_reg;

    unique case (state_reg)
      ST_STARTUP: begin
        if (cnt_reg == STARTUP_LAST) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      ST_IDLE: begin
        if (enable) begin
          state_next = ST_VSYNC;
          cnt_next   = '0;
          mode_next  = mode;
        end
      end
      ST_VSYNC: begin
        if (cnt_reg == VSYNC_LAST) begin
          state_next = ST_VBP;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      ST_VBP: begin
        if (cnt_reg == VBP_LAST) begin
          state_next = ST_ACTIVE;
          cnt_next   = '0;
          line_next  = '0;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      ST_ACTIVE: begin
        if (cnt_reg == BEAT_LAST) begin
          state_next = ST_HBLANK;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      ST_HBLANK: begin
        if (cnt_reg == HBLANK_LAST) begin
          cnt_next = '0;
          if (line_reg != LINE_LAST) begin
            state_next = ST_ACTIVE;
            line_next  = line_reg + LINE_ONE;
          end else begin
            // Frame boundary: the only place besides IDLE where enable and mode are sampled.
            frame_cnt_next = frame_cnt_reg + 16'd1;
            if (enable) begin
              state_next = ST_VSYNC;
              mode_next  = mode;
            end else begin
              state_next = ST_IDLE;
            end
          end
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      default: begin
        state_next = ST_STARTUP;
        cnt_next   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next-state values so they can be registered
  // without adding a cycle of latency.
  always_comb begin
    in_active  = (state_next == ST_ACTIVE);
    vsync_next = (state_next == ST_VSYNC);
    href_next  = in_active;
    busy_next  = (state_next == ST_VSYNC) || (state_next == ST_VBP) ||
                 (state_next == ST_ACTIVE) || (state_next == ST_HBLANK);
    done_next  = (state_next == ST_HBLANK) && (line_next == LINE_LAST) &&
                 (cnt_next == HBLANK_LAST);
    data_next  = '0;

    unique case (mode_next)
      2'd0: data_next = rot_next;
      2'd1: begin
        if (in_active) data_next = DATA_WIDTH'(cnt_next);
      end
      2'd2: begin
        if (in_active) data_next = DATA_WIDTH'(line_next) + DATA_WIDTH'(frame_cnt_next);
      end
      2'd3: begin
        if (in_active) data_next = {DATA_WIDTH{beat_b3 ^ line_b3}};
      end
      default: data_next = '0;
    endcase
  end

  always_ff @(posedge cam_pclk) begin
    if (cam_rst) begin
      state_reg     <= ST_STARTUP;
      cnt_reg       <= '0;
      line_reg      <= '0;
      mode_reg      <= 2'd0;
      frame_cnt_reg <= 16'd0;
      rot_reg       <= SEED_EXT;
      vsync_reg     <= 1'b0;
      href_reg      <= 1'b0;
      data_reg      <= SEED_EXT;
      done_reg      <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      line_reg      <= line_next;
      mode_reg      <= mode_next;
      frame_cnt_reg <= frame_cnt_next;
      rot_reg       <= rot_next;
      vsync_reg     <= vsync_next;
      href_reg      <= href_next;
      data_reg      <= data_next;
      done_reg      <= done_next;
      busy_reg      <= busy_next;
    end
  end

  assign cam_vsync  = vsync_reg;
  assign cam_href   = href_reg;
  assign cam_data   = data_reg;
  assign frame_cnt  = frame_cnt_reg;
  assign frame_done = done_reg;
  assign busy       = busy_reg;

endmodule

// File: tb/tb_cam_pattern_gen.sv
// Scoreboard bench for cam_pattern_gen: stimulus pushes expected events with their
// cycle numbers, a negedge monitor pops and compares them as the DUT produces them.
module tb_cam_pattern_gen;

  localparam int W   = 4;
  localparam int BPP = 2;
  localparam int H   = 3;
  localparam int VS  = 5;
  localparam int VBP = 3;
  localparam int HB  = 2;
  localparam int ST  = 10;
  localparam int DW  = 8;
  localparam int LB  = W * BPP;

  logic          cam_pclk = 1'b0;
  logic          cam_rst  = 1'b1;
  logic          enable   = 1'b0;
  logic [1:0]    mode     = 2'd0;
  logic          cam_vsync;
  logic          cam_href;
  logic [DW-1:0] cam_data;
  logic [15:0]   frame_cnt;
  logic          frame_done;
  logic          busy;

  cam_pattern_gen #(
    .FRAME_WIDTH     (W),
    .FRAME_HEIGHT    (H),
    .BYTES_PER_PIXEL (BPP),
    .DATA_WIDTH      (DW),
    .VSYNC_CYCLES    (VS),
    .VBP_CYCLES      (VBP),
    .HBLANK_CYCLES   (HB),
    .STARTUP_CYCLES  (ST),
    .SEED            (8'hEE)
  ) dut (
    .cam_pclk   (cam_pclk),
    .cam_rst    (cam_rst),
    .enable     (enable),
    .mode       (mode),
    .cam_vsync  (cam_vsync),
    .cam_href   (cam_href),
    .cam_data   (cam_data),
    .frame_cnt  (frame_cnt),
    .frame_done (frame_done),
    .busy       (busy)
  );

  always #5 cam_pclk = ~cam_pclk;

  // Cycle 0 is the first cycle after the last reset edge.
  int cyc = 0;
  always @(posedge cam_pclk) cyc <= cam_rst ? 0 : cyc + 1;

  typedef struct {
    int cyc;
    int data;
  } exp_t;

  exp_t q_pix[$];
  exp_t q_raw[$];
  exp_t q_vs[$];
  exp_t q_fd[$];
  exp_t q_fc[$];
  exp_t q_bf[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input int got, input int want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic chk_evt(input string name, input int got_c, input int got_d, input exp_t e);
    n_checks++;
    if (got_c != e.cyc || got_d != e.data) begin
      n_errors++;
      $display("FAIL %s: got data %0h at cycle %0d, expected data %0h at cycle %0d",
               name, got_d, got_c, e.data, e.cyc);
    end
  endtask

  task automatic unexpected(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: unexpected event at cycle %0d", name, cyc);
  endtask

  function automatic int rot_at(input int c);
    int tbl[4];
    tbl = '{'hEE, 'hDD, 'hBB, 'h77};
    return tbl[c % 4];
  endfunction

  function automatic int pix(input int m, input int l, input int b, input int fc, input int c);
    case (m)
      0:       return rot_at(c);
      1:       return b;
      2:       return l + fc;
      default: return ((((b >> 3) ^ (l >> 3)) & 1) != 0) ? 'hFF : 'h00;
    endcase
  endfunction

  // Frame starting (first vsync cycle) at s: 24 beats, done at s+37, new count at s+38.
  task automatic expect_frame(input int s, input int m, input int fc);
    q_vs.push_back('{s, 0});
    for (int l = 0; l < H; l++) begin
      for (int b = 0; b < LB; b++) begin
        int c;
        c = s + VS + VBP + l * (LB + HB) + b;
        q_pix.push_back('{c, pix(m, l, b, fc, c)});
      end
    end
    q_fd.push_back('{s + 37, 1});
    q_fc.push_back('{s + 38, fc + 1});
  endtask

  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge cam_pclk);
      #1;
    end
  endtask

  task automatic start_reset();
    cam_rst = 1'b1;
    @(posedge cam_pclk);
    @(posedge cam_pclk);
    #1;
  endtask

  task automatic release_reset();
    cam_rst = 1'b0;
    chk("rst_vsync", int'(cam_vsync), 0);
    chk("rst_href", int'(cam_href), 0);
    chk("rst_data", int'(cam_data), 'hEE);
    chk("rst_frame_cnt", int'(frame_cnt), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_busy", int'(busy), 0);
  endtask

  task automatic drain(input string tag);
    chk({tag, "_pix_left"}, q_pix.size(), 0);
    chk({tag, "_raw_left"}, q_raw.size(), 0);
    chk({tag, "_vsync_left"}, q_vs.size(), 0);
    chk({tag, "_done_left"}, q_fd.size(), 0);
    chk({tag, "_fcnt_left"}, q_fc.size(), 0);
    chk({tag, "_busyfall_left"}, q_bf.size(), 0);
  endtask

  // Monitor
  initial begin
    logic prev_vsync;
    logic prev_busy;
    int   prev_fc;
    int   vs_len;
    exp_t e;
    prev_vsync = 1'b0;
    prev_busy  = 1'b0;
    prev_fc    = 0;
    vs_len     = 0;
    forever begin
      @(negedge cam_pclk);
      if (cam_rst) begin
        prev_vsync = 1'b0;
        prev_busy  = 1'b0;
        prev_fc    = 0;
        vs_len     = 0;
      end else begin
        while (q_raw.size() > 0 && q_raw[0].cyc <= cyc) begin
          e = q_raw.pop_front();
          chk_evt("raw_data", cyc, int'(cam_data), e);
        end
        if (cam_href) begin
          if (q_pix.size() == 0) unexpected("pixel");
          else begin
            e = q_pix.pop_front();
            chk_evt("pixel", cyc, int'(cam_data), e);
          end
        end
        if (cam_href && cam_vsync) unexpected("vsync_href_overlap");
        if (cam_vsync && !prev_vsync) begin
          chk("busy_at_vsync", int'(busy), 1);
          if (q_vs.size() == 0) unexpected("vsync_rise");
          else begin
            e = q_vs.pop_front();
            chk_evt("vsync_rise", cyc, 0, e);
          end
        end
        if (cam_vsync) vs_len++;
        if (!cam_vsync && prev_vsync) begin
          chk("vsync_len", vs_len, VS);
          vs_len = 0;
        end
        if (frame_done) begin
          if (q_fd.size() == 0) unexpected("frame_done");
          else begin
            e = q_fd.pop_front();
            chk_evt("frame_done", cyc, 1, e);
          end
        end
        if (int'(frame_cnt) != prev_fc) begin
          if (q_fc.size() == 0) unexpected("frame_cnt");
          else begin
            e = q_fc.pop_front();
            chk_evt("frame_cnt", cyc, int'(frame_cnt), e);
          end
        end
        if (prev_busy && !busy) begin
          if (q_bf.size() == 0) unexpected("busy_fall");
          else begin
            e = q_bf.pop_front();
            chk_evt("busy_fall", cyc, 0, e);
          end
        end
        prev_vsync = cam_vsync;
        prev_busy  = busy;
        prev_fc    = int'(frame_cnt);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Stimulus
  initial begin
    // RAMP, continuous then enable drop mid-line-1 and re-raise
    mode   = 2'd1;
    enable = 1'b1;
    start_reset();
    q_raw.push_back('{10, 'hBB});
    q_raw.push_back('{11, 0});
    q_raw.push_back('{13, 0});
    q_raw.push_back('{17, 0});
    q_raw.push_back('{27, 0});
    q_raw.push_back('{28, 0});
    expect_frame(11, 1, 0);
    expect_frame(49, 1, 1);
    q_bf.push_back('{87, 0});
    expect_frame(101, 1, 2);
    q_bf.push_back('{139, 0});
    release_reset();
    goto(70);
    enable = 1'b0;
    goto(100);
    enable = 1'b1;
    goto(110);
    enable = 1'b0;
    goto(160);
    drain("ramp");

    // ROTATE through STARTUP, IDLE, VSYNC and ACTIVE
    mode   = 2'd0;
    enable = 1'b1;
    start_reset();
    for (int c = 0; c <= 12; c++) q_raw.push_back('{c, rot_at(c)});
    expect_frame(11, 0, 0);
    q_bf.push_back('{49, 0});
    release_reset();
    goto(20);
    enable = 1'b0;
    goto(60);
    drain("rotate");

    // LINE over two frames, mid-frame switch to CHECKER lands on frame 2
    mode   = 2'd2;
    enable = 1'b1;
    start_reset();
    expect_frame(11, 2, 0);
    expect_frame(49, 2, 1);
    expect_frame(87, 3, 2);
    q_bf.push_back('{125, 0});
    release_reset();
    goto(60);
    mode = 2'd3;
    goto(95);
    enable = 1'b0;
    goto(140);
    drain("line");

    // Reset mid-ACTIVE, then a full STARTUP repeats with the new mode
    mode   = 2'd1;
    enable = 1'b1;
    start_reset();
    q_vs.push_back('{11, 0});
    q_raw.push_back('{13, 0});
    q_pix.push_back('{19, 0});
    q_pix.push_back('{20, 1});
    release_reset();
    goto(21);
    cam_rst = 1'b1;
    mode    = 2'd2;
    @(posedge cam_pclk);
    #1;
    q_raw.push_back('{10, 'hBB});
    expect_frame(11, 2, 0);
    q_bf.push_back('{49, 0});
    release_reset();
    goto(20);
    enable = 1'b0;
    goto(70);
    drain("midreset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
